// File: rtl/ysyx_210247_clint_pkg.sv
// Shared constants, FSM encoding and the byte-strobe merge helper for the CLINT.
package ysyx_210247_clint_pkg;

  localparam int unsigned RW_DATA_WIDTH = 128;
  localparam logic [63:0] CLINT_BASE    = 64'h0200_0000;
  localparam logic [15:0] MTIME_OFF     = 16'hBFF8;
  localparam logic [15:0] MTIMECMP_OFF  = 16'h4000;

  typedef enum logic [1:0] {
    StIdle,
    StLocal,
    StPass
  } clint_state_e;

  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_210247_clint_regs.sv
// mtime/mtimecmp storage, tick divider, strobe-merged writes and the timer interrupt flop.
module ysyx_210247_clint_regs
  import ysyx_210247_clint_pkg::*;
#(
  parameter int unsigned TickDiv = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_mtime_i,
  input  logic        wr_mtimecmp_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wstrb_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        timer_int_o
);

  localparam int unsigned CntW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            timer_int_q, timer_int_d;
  logic            tick;

  always_comb begin
    tick       = (cnt_q == CntMax);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    // A software write to mtime swallows a coincident tick.
    mtime_d    = mtime_q;
    if (wr_mtime_i) begin
      mtime_d = strb_merge(mtime_q, wdata_i, wstrb_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    mtimecmp_d = wr_mtimecmp_i ? strb_merge(mtimecmp_q, wdata_i, wstrb_i) : mtimecmp_q;
    timer_int_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_int_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign mtime_o     = mtime_q;
  assign mtimecmp_o  = mtimecmp_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/ysyx_210247_clint.sv
// CLINT sitting between the dcache and the AXI bridge: serves its own window locally,
// forwards everything else untouched, and raises the machine timer interrupt.
module ysyx_210247_clint
  import ysyx_210247_clint_pkg::*;
#(
  parameter logic [63:0] ClintBase = CLINT_BASE,
  parameter int unsigned TickDiv   = 1,
  parameter int unsigned RwW       = RW_DATA_WIDTH
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [63:0]    up_req_addr,
  input  logic [RwW-1:0] up_req_data,
  input  logic           up_req_wen,
  input  logic [1:0]     up_req_size,
  input  logic [7:0]     up_req_strb,
  input  logic           up_req_valid,
  output logic           up_resp_valid,
  output logic [RwW-1:0] up_resp_data,
  output logic [63:0]    dn_req_addr,
  output logic [RwW-1:0] dn_req_data,
  output logic           dn_req_wen,
  output logic [1:0]     dn_req_size,
  output logic [7:0]     dn_req_strb,
  output logic           dn_req_valid,
  input  logic           dn_resp_valid,
  input  logic [RwW-1:0] dn_resp_data,
  output logic           timer_int
);

  clint_state_e state_q, state_d;
  logic [63:0]  rdata_q, rdata_d;
  logic [63:0]  mtime, mtimecmp, rd64;
  logic [15:0]  off;
  logic         hit, accept_local, wr_mtime, wr_mtimecmp;

  always_comb begin
    off          = up_req_addr[15:0];
    hit          = (up_req_addr[63:16] == ClintBase[63:16]);
    accept_local = (state_q == StIdle) && up_req_valid && hit;
    wr_mtime     = accept_local && up_req_wen && (off == MTIME_OFF);
    wr_mtimecmp  = accept_local && up_req_wen && (off == MTIMECMP_OFF);
    if (off == MTIME_OFF) begin
      rd64 = mtime;
    end else if (off == MTIMECMP_OFF) begin
      rd64 = mtimecmp;
    end else begin
      rd64 = '0;
    end
    rdata_d = accept_local ? rd64 : rdata_q;
  end

  always_comb begin
    state_d       = state_q;
    dn_req_valid  = 1'b0;
    up_resp_valid = 1'b0;
    up_resp_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (up_req_valid) begin
          if (hit) begin
            state_d = StLocal;
          end else begin
            state_d      = StPass;
            dn_req_valid = 1'b1;
          end
        end
      end
      StLocal: begin
        // Both halves carry the value; the dcache picks a lane by addr[3].
        up_resp_valid = 1'b1;
        up_resp_data  = {(RwW/64){rdata_q}};
        state_d       = StIdle;
      end
      StPass: begin
        dn_req_valid  = up_req_valid;
        up_resp_valid = dn_resp_valid;
        up_resp_data  = dn_resp_data;
        if (dn_resp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset must kill an in-flight bridge request within the same cycle.
    if (reset) begin
      dn_req_valid  = 1'b0;
      up_resp_valid = 1'b0;
      up_resp_data  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign dn_req_addr = up_req_addr;
  assign dn_req_data = up_req_data;
  assign dn_req_wen  = up_req_wen;
  assign dn_req_size = up_req_size;
  assign dn_req_strb = up_req_strb;

  ysyx_210247_clint_regs #(
    .TickDiv(TickDiv)
  ) u_regs (
    .clock        (clock),
    .reset        (reset),
    .wr_mtime_i   (wr_mtime),
    .wr_mtimecmp_i(wr_mtimecmp),
    .wdata_i      (up_req_data[63:0]),
    .wstrb_i      (up_req_strb),
    .mtime_o      (mtime),
    .mtimecmp_o   (mtimecmp),
    .timer_int_o  (timer_int)
  );

endmodule
